// File: rtl/systolic_array_os_if.sv
// Job control, operand-beat and result-row bundle for systolic_array_os.
interface systolic_array_os_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned NUM_ROW    = 3,
  parameter int unsigned NUM_COL    = 3
);
  logic                          start;
  logic [15:0]                   k_len;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_ROW*DATA_WIDTH-1:0] in_ifmap;
  logic [NUM_COL*DATA_WIDTH-1:0] in_fltr;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_COL*ACC_WIDTH-1:0]  out_psum;
  logic                          out_last;
  logic                          busy;
  logic                          done;

  modport master (
    output start, k_len, in_valid, in_ifmap, in_fltr, out_ready,
    input  in_ready, out_valid, out_psum, out_last, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_ifmap, in_fltr, out_ready,
    output in_ready, out_valid, out_psum, out_last, busy, done
  );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary NUM_ROW x NUM_COL systolic array: A columns stream in from
// the left, B rows from the top, each PE accumulates locally, and the result
// matrix is drained one row per handshake.
module systolic_array_os #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned NUM_ROW    = 3,
  parameter int unsigned NUM_COL    = 3
) (
  input  logic                clk,
  input  logic                rst,
  systolic_array_os_if.slave  bus
);

  localparam int unsigned FLUSH_CNT = NUM_ROW + NUM_COL - 1;
  localparam int unsigned FLUSH_W   = $clog2(FLUSH_CNT + 1);
  localparam int unsigned ROW_W     = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [15:0]        k_len_q, k_len_d;
  logic [15:0]        beat_q, beat_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               done_q, done_d;
  logic               step;
  logic               clear;

  logic signed [DATA_WIDTH-1:0] a_lane [NUM_ROW];
  logic signed [DATA_WIDTH-1:0] b_lane [NUM_COL];
  logic signed [DATA_WIDTH-1:0] a_edge [NUM_ROW];
  logic signed [DATA_WIDTH-1:0] b_edge [NUM_COL];

  // Skew delay lines; lane i uses entries [i][0..i-1] only.
  logic signed [DATA_WIDTH-1:0] a_sk_q [NUM_ROW][NUM_ROW];
  logic signed [DATA_WIDTH-1:0] a_sk_d [NUM_ROW][NUM_ROW];
  logic signed [DATA_WIDTH-1:0] b_sk_q [NUM_COL][NUM_COL];
  logic signed [DATA_WIDTH-1:0] b_sk_d [NUM_COL][NUM_COL];

  logic signed [DATA_WIDTH-1:0] a_pe_q [NUM_ROW][NUM_COL];
  logic signed [DATA_WIDTH-1:0] a_pe_d [NUM_ROW][NUM_COL];
  logic signed [DATA_WIDTH-1:0] b_pe_q [NUM_ROW][NUM_COL];
  logic signed [DATA_WIDTH-1:0] b_pe_d [NUM_ROW][NUM_COL];
  logic signed [ACC_WIDTH-1:0]  acc_q  [NUM_ROW][NUM_COL];
  logic signed [ACC_WIDTH-1:0]  acc_d  [NUM_ROW][NUM_COL];

  logic signed [DATA_WIDTH-1:0]   a_w;
  logic signed [DATA_WIDTH-1:0]   b_n;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic [NUM_COL*ACC_WIDTH-1:0]   psum;

  // Job sequencing: capture, beat counting, flush countdown, row drain.
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          k_len_d = bus.k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          step   = 1'b1;
          beat_d = beat_q + 16'd1;
          if (beat_q + 16'd1 == k_len_q) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        step    = 1'b1;
        flush_d = flush_q + FLUSH_W'(1);
        if (flush_q == FLUSH_W'(FLUSH_CNT - 1)) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == ROW_W'(NUM_ROW - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Operand lanes: live data while loading, zeros while flushing.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ROW; i++) begin
      a_lane[i] = (state_q == LOAD) ? $signed(bus.in_ifmap[i*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end
    for (int unsigned j = 0; j < NUM_COL; j++) begin
      b_lane[j] = (state_q == LOAD) ? $signed(bus.in_fltr[j*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end
  end

  // Skew lines: lane i (or j) reaches the array edge i (or j) steps late.
  always_comb begin
    a_sk_d = a_sk_q;
    b_sk_d = b_sk_q;
    for (int unsigned i = 0; i < NUM_ROW; i++) begin
      if (i == 0) a_edge[i] = a_lane[i];
      else        a_edge[i] = a_sk_q[i][i-1];
    end
    for (int unsigned j = 0; j < NUM_COL; j++) begin
      if (j == 0) b_edge[j] = b_lane[j];
      else        b_edge[j] = b_sk_q[j][j-1];
    end
    if (clear) begin
      a_sk_d = '{default: '0};
      b_sk_d = '{default: '0};
    end else if (step) begin
      for (int unsigned i = 0; i < NUM_ROW; i++) begin
        for (int unsigned s = 0; s < i; s++) begin
          if (s == 0) a_sk_d[i][s] = a_lane[i];
          else        a_sk_d[i][s] = a_sk_q[i][s-1];
        end
      end
      for (int unsigned j = 0; j < NUM_COL; j++) begin
        for (int unsigned s = 0; s < j; s++) begin
          if (s == 0) b_sk_d[j][s] = b_lane[j];
          else        b_sk_d[j][s] = b_sk_q[j][s-1];
        end
      end
    end
  end

  // PE grid: forward A right and B down, accumulate the product with wrap.
  always_comb begin
    a_pe_d   = a_pe_q;
    b_pe_d   = b_pe_q;
    acc_d    = acc_q;
    a_w      = '0;
    b_n      = '0;
    prod     = '0;
    prod_ext = '0;
    if (clear) begin
      a_pe_d = '{default: '0};
      b_pe_d = '{default: '0};
      acc_d  = '{default: '0};
    end else if (step) begin
      for (int unsigned i = 0; i < NUM_ROW; i++) begin
        for (int unsigned j = 0; j < NUM_COL; j++) begin
          if (j == 0) a_w = a_edge[i];
          else        a_w = a_pe_q[i][j-1];
          if (i == 0) b_n = b_edge[j];
          else        b_n = b_pe_q[i-1][j];
          prod          = (2*DATA_WIDTH)'(a_w) * (2*DATA_WIDTH)'(b_n);
          prod_ext      = ACC_WIDTH'(prod);
          a_pe_d[i][j]  = a_w;
          b_pe_d[i][j]  = b_n;
          acc_d[i][j]   = acc_q[i][j] + prod_ext;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sk_q <= '{default: '0};
      b_sk_q <= '{default: '0};
      a_pe_q <= '{default: '0};
      b_pe_q <= '{default: '0};
      acc_q  <= '{default: '0};
    end else begin
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
      a_pe_q <= a_pe_d;
      b_pe_q <= b_pe_d;
      acc_q  <= acc_d;
    end
  end

  // Result row mux, forced to zero outside DRAIN.
  always_comb begin
    psum = '0;
    if (state_q == DRAIN) begin
      for (int unsigned j = 0; j < NUM_COL; j++) begin
        psum[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (row_q == ROW_W'(NUM_ROW - 1));
  assign bus.out_psum  = psum;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench for systolic_array_os: a 40-bit accumulator instance for
// the main jobs and a 32-bit instance for the accumulator wrap case.
module tb_systolic_array_os;
  localparam int DW = 16;
  localparam int NR = 3;
  localparam int NC = 3;

  typedef struct {
    longint v [NC];
    bit     last;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_os_if #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .NUM_ROW(NR), .NUM_COL(NC)) bus40 ();
  systolic_array_os_if #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .NUM_ROW(NR), .NUM_COL(NC)) bus32 ();

  systolic_array_os #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .NUM_ROW(NR), .NUM_COL(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus40)
  );

  systolic_array_os #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .NUM_ROW(NR), .NUM_COL(NC)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  logic             start, sel32, in_valid, out_ready, stall_out, gaps;
  logic [15:0]      k_len;
  logic [NR*DW-1:0] in_ifmap;
  logic [NC*DW-1:0] in_fltr;

  assign bus40.start     = start & ~sel32;
  assign bus32.start     = start & sel32;
  assign bus40.k_len     = k_len;
  assign bus32.k_len     = k_len;
  assign bus40.in_valid  = in_valid & ~sel32;
  assign bus32.in_valid  = in_valid & sel32;
  assign bus40.in_ifmap  = in_ifmap;
  assign bus32.in_ifmap  = in_ifmap;
  assign bus40.in_fltr   = in_fltr;
  assign bus32.in_fltr   = in_fltr;
  assign bus40.out_ready = out_ready;
  assign bus32.out_ready = out_ready;

  logic cur_in_ready, cur_out_valid, cur_busy, cur_done;
  assign cur_in_ready  = sel32 ? bus32.in_ready  : bus40.in_ready;
  assign cur_out_valid = sel32 ? bus32.out_valid : bus40.out_valid;
  assign cur_busy      = sel32 ? bus32.busy      : bus40.busy;
  assign cur_done      = sel32 ? bus32.done      : bus40.done;

  int     checks = 0;
  int     errors = 0;
  int     A [NR][3];
  int     B [3][NC];
  longint E [NR][NC];
  row_t   q40 [$];
  row_t   q32 [$];
  bit     prev_stall [2];
  longint prev_got [2][NC];

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: hold-stability while stalled, then pop/compare on each handshake.
  task automatic monitor(input int p, input logic vld, input logic rdy, input logic last,
                         input longint got [NC]);
    row_t e;
    if (prev_stall[p]) begin
      for (int j = 0; j < NC; j++) chk($sformatf("p%0d_hold_psum_lane%0d", p, j), got[j], prev_got[p][j]);
      chk($sformatf("p%0d_hold_valid", p), vld, 1);
    end
    prev_stall[p] = vld && !rdy;
    for (int j = 0; j < NC; j++) prev_got[p][j] = got[j];
    if (vld && rdy) begin
      if ((p == 0 && q40.size() == 0) || (p == 1 && q32.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL p%0d_unexpected_row: got a row expected none", p);
      end else begin
        if (p == 0) e = q40.pop_front();
        else        e = q32.pop_front();
        for (int j = 0; j < NC; j++) chk($sformatf("p%0d_psum_lane%0d", p, j), got[j], e.v[j]);
        chk($sformatf("p%0d_out_last", p), last, e.last);
      end
    end
  endtask

  always @(negedge clk) begin
    longint g40 [NC];
    longint g32 [NC];
    for (int j = 0; j < NC; j++) begin
      g40[j] = longint'($signed(bus40.out_psum[j*40 +: 40]));
      g32[j] = longint'($signed(bus32.out_psum[j*32 +: 32]));
    end
    monitor(0, bus40.out_valid, bus40.out_ready, bus40.out_last, g40);
    monitor(1, bus32.out_valid, bus32.out_ready, bus32.out_last, g32);
  end

  // Result-side backpressure: when stalling, each row sees 5 low cycles first.
  initial begin
    int cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_out) out_ready = 1'b1;
      else if (out_ready) begin
        out_ready = 1'b0;
        cnt = 0;
      end else if (cur_out_valid) begin
        cnt++;
        if (cnt >= 5) out_ready = 1'b1;
      end
    end
  end

  task automatic start_job(input int kl);
    row_t e;
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < NC; j++) e.v[j] = E[r][j];
      e.last = (r == NR - 1);
      if (sel32) q32.push_back(e);
      else       q40.push_back(e);
    end
    start = 1'b1;
    k_len = 16'(kl);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int nb);
    int b = 0;
    int guard = 0;
    bit hs;
    while (b < nb && guard < 200) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        for (int i = 0; i < NR; i++) in_ifmap[i*DW +: DW] = DW'(A[i][b]);
        for (int j = 0; j < NC; j++) in_fltr[j*DW +: DW]  = DW'(B[b][j]);
      end
      @(negedge clk);
      hs = in_valid && cur_in_ready;
      @(posedge clk); #1;
      if (hs) b++;
    end
    in_valid = 1'b0;
    chk("feed_beats_accepted", b, nb);
  endtask

  task automatic wait_done(input string tag, input int budget, output bit saw_ready);
    int n = 0;
    bit seen = 0;
    bit early = 0;
    saw_ready = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (cur_in_ready) saw_ready = 1;
      if (cur_done) seen = 1;
      else if (!cur_busy) early = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, cur_busy, 0);
      chk({tag, "_busy_low_before_done"}, early, 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, cur_done, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus40.in_ready, 0);
    chk({tag, "_out_valid"}, bus40.out_valid, 0);
    chk({tag, "_out_last"},  bus40.out_last, 0);
    chk({tag, "_out_psum"},  |bus40.out_psum, 0);
    chk({tag, "_busy"},      bus40.busy, 0);
    chk({tag, "_done"},      bus40.done, 0);
    chk({tag, "_busy32"},    bus32.busy, 0);
  endtask

  task automatic set_ab_identity();
    A = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    B = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    E = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
  endtask

  task automatic set_ab_signed();
    A = '{'{1, -2, 3}, '{0, 1, 0}, '{2, 0, -1}};
    B = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    E = '{'{14, 16, 18}, '{4, 5, 6}, '{-5, -4, -3}};
  endtask

  initial begin
    bit saw;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0; sel32 = 1'b0; in_valid = 1'b0; k_len = '0;
    in_ifmap = '0; in_fltr = '0; stall_out = 1'b0; gaps = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Identity times B, continuous in_valid.
    set_ab_identity();
    start_job(3);
    feed(3);
    wait_done("ident", 100, saw);

    // Mixed signs exercise the skew alignment across all k.
    set_ab_signed();
    start_job(3);
    feed(3);
    wait_done("signed", 100, saw);

    // Most-negative operands: (-32768)^2 = 2^30 per PE.
    A = '{'{-32768, 0, 0}, '{-32768, 0, 0}, '{-32768, 0, 0}};
    B = '{'{-32768, -32768, -32768}, '{0, 0, 0}, '{0, 0, 0}};
    E = '{default: '{default: 64'sd1073741824}};
    start_job(1);
    feed(1);
    wait_done("minneg", 100, saw);

    // Input gaps and output backpressure.
    set_ab_identity();
    gaps = 1'b1;
    stall_out = 1'b1;
    start_job(3);
    feed(3);
    wait_done("stall", 300, saw);
    gaps = 1'b0;
    stall_out = 1'b0;

    // Zero-depth job: no operand beats, three zero rows.
    E = '{default: '{default: 64'sd0}};
    start_job(0);
    wait_done("k0", 100, saw);
    chk("k0_no_in_ready", saw, 0);

    // Reset in the middle of LOAD, then a clean job.
    set_ab_signed();
    start_job(3);
    feed(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload");
    q40.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    start_job(3);
    feed(3);
    wait_done("after_rst", 100, saw);

    // Start raised during DRAIN must not disturb the running job.
    set_ab_identity();
    start_job(3);
    feed(3);
    begin
      int n = 0;
      while (!cur_out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("drain_reached", cur_out_valid, 1);
    end
    start = 1'b1;
    k_len = 16'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("drain_start", 100, saw);
    repeat (3) @(negedge clk);
    chk("drain_start_stays_idle", cur_busy, 0);
    chk("drain_start_no_load", cur_in_ready, 0);

    // 32-bit accumulator: 2 * 2^30 wraps to -2^31.
    sel32 = 1'b1;
    A = '{'{-32768, -32768, 0}, '{-32768, -32768, 0}, '{-32768, -32768, 0}};
    B = '{'{-32768, -32768, -32768}, '{-32768, -32768, -32768}, '{0, 0, 0}};
    E = '{default: '{default: -64'sd2147483648}};
    start_job(2);
    feed(2);
    wait_done("wrap32", 100, saw);
    sel32 = 1'b0;

    repeat (2) @(negedge clk);
    chk("sb40_empty", q40.size(), 0);
    chk("sb32_empty", q32.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
